// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with extended-pointer full/empty detection,
// programmable almost flags, sticky error flags and a selectable FWFT read mode.
module fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // The extra pointer MSB distinguishes full from empty when the addresses match.
    always_comb begin
        fifo_empty   = (wr_ptr == rd_ptr);
        fifo_full    = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                       (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        fill_count   = wr_ptr - rd_ptr;
        almost_full  = (fill_count >= AFULL_LVL);
        almost_empty = (fill_count <= AEMPTY_LVL);
        wr_accept    = wr_en && !fifo_full;
        rd_accept    = rd_en && !fifo_empty;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left without reset so it maps onto RAM; flags never depend on it.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    // A new error event in the same cycle as err_clr takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && fifo_full) overflow <= 1'b1;
            else if (err_clr)       overflow <= 1'b0;
            if (rd_en && fifo_empty) underflow <= 1'b1;
            else if (err_clr)        underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] data_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         data_q <= '0;
                else if (rd_accept) data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed testbench for fifo_param: one registered-read instance and one FWFT instance.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en, err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] fill_count;

    logic       wr_en1, rd_en1, err_clr1;
    logic [7:0] data_in1;
    logic [7:0] data_out1;
    logic       fifo_full1, fifo_empty1, almost_full1, almost_empty1, overflow1, underflow1;
    logic [4:0] fill_count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_param #(.FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
        .data_in(data_in), .data_out(data_out), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(.FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .rd_en(rd_en1), .err_clr(err_clr1),
        .data_in(data_in1), .data_out(data_out1), .fifo_full(fifo_full1),
        .fifo_empty(fifo_empty1), .almost_full(almost_full1), .almost_empty(almost_empty1),
        .fill_count(fill_count1), .overflow(overflow1), .underflow(underflow1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        wr_en = w; rd_en = r; data_in = d;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({fill_count, fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow} !==
            {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b", fill_count,
                     fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out got %h expected 00", data_out);
        end
        checks++;
        if ({fill_count1, fifo_empty1, fifo_full1, overflow1, underflow1} !== {5'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_fwft_flags got cnt=%0d e=%b f=%b ov=%b un=%b", fill_count1,
                     fifo_empty1, fifo_full1, overflow1, underflow1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            checks++;
            if (fill_count !== 5'(i) || almost_empty !== (i <= 2) || almost_full !== (i >= 14) ||
                fifo_full !== (i == 16) || fifo_empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d got cnt=%0d ae=%b af=%b f=%b e=%b", i, fill_count,
                         almost_empty, almost_full, fifo_full, fifo_empty);
            end
        end
        drive(1'b1, 1'b0, 8'h99);
        checks++;
        if (fill_count !== 5'd16 || overflow !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_overflow got cnt=%0d ov=%b un=%b expected 16 1 0", fill_count,
                     overflow, underflow);
        end
        clear_errors();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_err_clr got ov=%b expected 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== 8'(i) || fill_count !== 5'(16 - i)) begin
                errors++;
                $display("FAIL drain_%0d got data=%h cnt=%0d expected %h %0d", i, data_out,
                         fill_count, 8'(i), 16 - i);
            end
        end
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got %b expected 1", fifo_empty);
        end
        drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (underflow !== 1'b1 || data_out !== 8'h10 || fill_count !== 5'd0) begin
            errors++;
            $display("FAIL drain_underflow got un=%b data=%h cnt=%0d expected 1 10 0", underflow,
                     data_out, fill_count);
        end
        clear_errors();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_err_clr got un=%b expected 0", underflow);
        end
    endtask

    // Words written are 0x20, 0x21, ... so the k-th read must return 0x20+k.
    task automatic test_back_to_back();
        int nrd = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h20 + i));
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b1, 8'(8'h25 + k));
            checks++;
            if (fill_count !== 5'd5 || data_out !== 8'(8'h20 + nrd)) begin
                errors++;
                $display("FAIL stream_%0d got cnt=%0d data=%h expected 5 %h", k, fill_count,
                         data_out, 8'(8'h20 + nrd));
            end
            nrd++;
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== 8'(8'h20 + nrd)) begin
                errors++;
                $display("FAIL stream_tail_%0d got %h expected %h", k, data_out, 8'(8'h20 + nrd));
            end
            nrd++;
        end
        checks++;
        if (fifo_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got e=%b ov=%b un=%b expected 1 0 0", fifo_empty, overflow,
                     underflow);
        end
    endtask

    task automatic test_boundaries();
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b1, 1'b1, 8'hEE);
        checks++;
        if (data_out !== 8'h01 || overflow !== 1'b1 || fill_count !== 5'd15) begin
            errors++;
            $display("FAIL full_rw got data=%h ov=%b cnt=%0d expected 01 1 15", data_out, overflow,
                     fill_count);
        end
        clear_errors();
        for (int i = 2; i <= 16; i++) drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h10 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_dropped got data=%h e=%b expected 10 1", data_out, fifo_empty);
        end
        drive(1'b1, 1'b1, 8'h3C);
        checks++;
        if (fill_count !== 5'd1 || underflow !== 1'b1 || data_out !== 8'h10) begin
            errors++;
            $display("FAIL empty_rw got cnt=%0d un=%b data=%h expected 1 1 10", fill_count,
                     underflow, data_out);
        end
        clear_errors();
        drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h3C || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw_readback got data=%h e=%b expected 3c 1", data_out, fifo_empty);
        end
    endtask

    task automatic test_fwft();
        wr_en1 = 1'b1; data_in1 = 8'hA5;
        tick();
        wr_en1 = 1'b0;
        checks++;
        if (fifo_empty1 !== 1'b0 || data_out1 !== 8'hA5 || fill_count1 !== 5'd1) begin
            errors++;
            $display("FAIL fwft_show got e=%b data=%h cnt=%0d expected 0 a5 1", fifo_empty1,
                     data_out1, fill_count1);
        end
        rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        checks++;
        if (fifo_empty1 !== 1'b1 || underflow1 !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop got e=%b un=%b expected 1 0", fifo_empty1, underflow1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
        drive(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (fill_count !== 5'd9 || overflow !== 1'b1 || data_out !== 8'h47) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d ov=%b data=%h expected 9 1 47", fill_count,
                     overflow, data_out);
        end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fill_count, fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow} !==
            {5'd0, 6'b101000} || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b data=%h",
                     fill_count, fifo_empty, fifo_full, almost_empty, almost_full, overflow,
                     underflow, data_out);
        end
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (fill_count !== 5'd0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_held got cnt=%0d e=%b expected 0 1", fill_count, fifo_empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 8'h77);
        drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h77 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got data=%h e=%b expected 77 1", data_out, fifo_empty);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        wr_en1 = 1'b0; rd_en1 = 1'b0; err_clr1 = 1'b0; data_in1 = 8'h00;
        test_reset();
        tick();
        test_fill();
        test_drain();
        test_back_to_back();
        test_boundaries();
        test_fwft();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
